// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write port, $0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile #(
  parameter int REG_NUM   = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [4:0]           waddr_i,
  input  logic [REG_WIDTH-1:0] wdata_i,
  input  logic                 re1_i,
  input  logic [4:0]           raddr1_i,
  output logic [REG_WIDTH-1:0] rdata1_o,
  input  logic                 re2_i,
  input  logic [4:0]           raddr2_i,
  output logic [REG_WIDTH-1:0] rdata2_o
);

  logic [REG_WIDTH-1:0] regs_q [REG_NUM];
  logic [REG_WIDTH-1:0] regs_d [REG_NUM];

  // Next-state of the array: one write per cycle, writes to $0 dropped
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = {REG_WIDTH{1'b0}};
  end

  // Storage array with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= {REG_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Port 1 read mux: reset, enable, zero register, bypass, array
  always_comb begin
    if (rst_i) begin
      rdata1_o = {REG_WIDTH{1'b0}};
    end else if (!re1_i) begin
      rdata1_o = {REG_WIDTH{1'b0}};
    end else if (raddr1_i == 5'd0) begin
      rdata1_o = {REG_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
`endif
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  // Port 2 read mux, same priority as port 1
  always_comb begin
    if (rst_i) begin
      rdata2_o = {REG_WIDTH{1'b0}};
    end else if (!re2_i) begin
      rdata2_o = {REG_WIDTH{1'b0}};
    end else if (raddr2_i == 5'd0) begin
      rdata2_o = {REG_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
`endif
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expectations are queued when reads are driven and checked when sampled.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  regfile dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .re1_i    (re1),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .re2_i    (re2),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int port, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, (e.port == 1) ? rdata1 : rdata2, e.exp);
    end
  endtask

  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

    // reset state
    @(negedge clk);
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    push_exp("reset_p1", 1, 32'h0); push_exp("reset_p2", 2, 32'h0);
    sample();
    rst = 1'b0;

    // async reset after a write to $5
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    @(negedge clk);
    we = 1'b0;
    push_exp("wr5_readback", 1, 32'hDEADBEEF);
    sample();
    #2;
    rst = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D;
    push_exp("rst_async_p1", 1, 32'h0);
    sample();
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    push_exp("rst_release_5", 1, 32'h0);
    sample();
    @(negedge clk);
    raddr2 = 5'd6;
    push_exp("rst_after_edge_5", 1, 32'h0);
    push_exp("rst_write_dropped_6", 2, 32'h0);
    sample();

    // basic write/read on both ports
    @(negedge clk);
    re1 = 1'b0; re2 = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'h00001234;
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    push_exp("basic_p1", 1, 32'h00001234); push_exp("basic_p2", 2, 32'h00001234);
    sample();

    // zero register
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    push_exp("zero_wcycle_p1", 1, 32'h0); push_exp("zero_wcycle_p2", 2, 32'h0);
    sample();
    @(negedge clk);
    we = 1'b0;
    push_exp("zero_after_p1", 1, 32'h0); push_exp("zero_after_p2", 2, 32'h0);
    sample();

    // read disable
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000ABCD;
    @(negedge clk);
    we = 1'b0; re1 = 1'b0; raddr1 = 5'd7;
    push_exp("rd_disabled", 1, 32'h0);
    sample();
    re1 = 1'b1;
    push_exp("rd_enabled", 1, 32'h0000ABCD);
    sample();

    // same-cycle write/read hazard
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h22222222;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
    push_exp("hazard_before_edge", 1, 32'h22222222);
`else
    push_exp("hazard_before_edge", 1, 32'h11111111);
`endif
    push_exp("hazard_other_port", 2, 32'h00001234);
    sample();
    @(negedge clk);
    we = 1'b0;
    push_exp("hazard_after_edge", 1, 32'h22222222);
    sample();

    // back-to-back writes to every writable register
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(i); wdata = 32'h100 + 32'(i);
    end
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      e1 = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
      push_exp($sformatf("sweep_p1_r%0d", i), 1, e1);
      push_exp($sformatf("sweep_p2_r%0d", 31 - i), 2, e2);
      sample();
      @(negedge clk);
    end

    if (sb_q.size() != 0) begin
      check_eq("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
